alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, multi-cycle successor to the datapath's combinational ALU. It adds a start/busy/done handshake, iterative multiply and shift operations, registered results, and a three-bit status word (Z, N, V). It sits in the datapath between the A/B operand registers and the C register/status register. The controller FSM issues `start` and waits on `done`.

## Interface
Parameters:
- `WIDTH`, default 16: operand and result width; must be ≥ 4 and a power of two.
- `SHW`, default $clog2(WIDTH): shift-amount width, derived; not overridden.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `start`, in, 1: request a new operation; sampled only when idle.
- `ALUop`, in, 3: operation code, captured with `start`.
- `Ain`, in, WIDTH: operand A, captured with `start`.
- `Bin`, in, WIDTH: operand B, captured with `start`.
- `busy`, out, 1: high while a multi-cycle operation is executing.
- `done`, out, 1: one-cycle pulse; `out`/`status` are updated at that edge.
- `out`, out, WIDTH: result register; holds until the next completion.
- `status`, out, 3: {Z, N, V}, registered together with `out`.

## Operation
Opcodes:
- 000 ADD: A+B.
- 001 SUB: A−B.
- 010 AND: A&B.
- 011 NOT: ~B.
- 100 MUL: unsigned A×B, low WIDTH bits.
- 101 LSL: A << B[SHW-1:0].
- 110 LSR: logical right shift.
- 111 ASR: arithmetic right shift.

States: IDLE, EXEC.
- IDLE + `start` + op 000–011: compute combinationally from the live inputs, then load `out`/`status` and pulse `done` at that edge. State stays IDLE.
- IDLE + `start` + op 100–111: capture Ain, Bin and the op; load the iteration counter; go to EXEC.
- EXEC, MUL: shift-add over a 2·WIDTH-bit accumulator, one multiplier bit per cycle, exactly WIDTH cycles.
- EXEC, shifts: one bit per cycle for shamt cycles. Shamt 0 takes exactly 1 cycle and yields out = A.
- EXEC, last iteration: load `out`/`status`, pulse `done`, return to IDLE at that edge.
- `start` while in EXEC is ignored; operands are not re-captured.
- `start` in the cycle `done` is high is accepted, because the state is already IDLE.

Flags:
- Z = (out == 0).
- N = out[WIDTH-1].
- V for ADD/SUB: two's-complement signed overflow.
- V for MUL: 1 if product bits [2·WIDTH-1:WIDTH] are non-zero.
- V for AND, NOT and shifts: 0.

Other rules:
- Arithmetic wraps modulo 2^WIDTH.
- Unused Bin bits are ignored for shifts.

## Timing
- Reset, asynchronous and immediate:
  - state = IDLE, `busy` = 0, `done` = 0.
  - `out` = 0, `status` = 3'b100 (Z=1).
  - Any in-flight operation is discarded; no `done` follows.
- Single-cycle ops: start sampled at edge k; `done` is high and `out` is valid during cycle k→k+1. Latency is 1.
- MUL: start at edge k; `busy` is high from k to k+WIDTH; `done` at edge k+WIDTH.
- Shifts: `done` at edge k+max(shamt, 1).
- `busy` and `done` are never high together.
- `busy` and `done` are registered; no combinational path from inputs to outputs.

## Structure
- Package `alu_pkg` holds:
  - opcode enum `alu_op_t` (3 bits);
  - state enum `alu_state_t`;
  - status bit-index constants `ST_Z`, `ST_N`, `ST_V`.
- One sub-module, `alu_comb`: combinational single-cycle ops plus the flag function (result → Z/N, op+operands → V), parametrised by WIDTH.
- The top level holds the FSM, iteration counter, operand/accumulator registers and output registers.

## Test plan
All scenarios use WIDTH=16.
- ADD 0x7FFF + 0x0001 → out 0x8000, status {Z=0, N=1, V=1}; `done` 1 cycle after start; `busy` never high.
- SUB 0x0005 − 0x0005 → out 0x0000, status 3'b100. A back-to-back NOT of Bin 0x00FF started in the `done` cycle → out 0xFF00, N=1.
- MUL 0x0100 × 0x0100 → out 0x0000, Z=1, V=1. `busy` high exactly 16 cycles, `done` at edge 16. A second `start` with ADD at cycle 4 is ignored and the result is unchanged.
- ASR 0x8000 by 3 → 0xF000, N=1, `done` after 3 cycles. LSR 0x8000 by 3 → 0x1000. LSL 0x1234 by 0 → 0x1234 after 1 cycle.
- Reset asserted asynchronously mid-edge, 5 cycles into MUL 0x0003 × 0x0005 → `busy`=0 and out=0 immediately, status 3'b100, no `done` pulse. A restarted MUL → out 0x000F after 16 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle datapath ALU: opcodes, controller states
// and the bit positions of the {Z, N, V} status word.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_NOT = 3'b011,
    OP_MUL = 3'b100,
    OP_LSL = 3'b101,
    OP_LSR = 3'b110,
    OP_ASR = 3'b111
  } alu_op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } alu_state_t;

  localparam int ST_V = 0;
  localparam int ST_N = 1;
  localparam int ST_Z = 2;

  localparam logic [2:0] STATUS_RST = 3'b100;

endpackage

// File: rtl/alu_comb.sv
// Combinational single-cycle operations and the status-flag function.
// Multi-cycle ops pass their finished result through here so every path shares one flag encoder.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  alu_op_t          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] seq_res_i,
  input  logic             seq_ovf_i,
  output logic [WIDTH-1:0] res_o,
  output logic [2:0]       status_o
);

  localparam int MSB = WIDTH - 1;

  logic ovf;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    res_o = seq_res_i;
    ovf   = 1'b0;
    case (op_i)
      OP_ADD: begin
        res_o = a_i + b_i;
        ovf   = (a_i[MSB] == b_i[MSB]) && (res_o[MSB] != a_i[MSB]);
      end
      OP_SUB: begin
        res_o = a_i - b_i;
        ovf   = (a_i[MSB] != b_i[MSB]) && (res_o[MSB] != a_i[MSB]);
      end
      OP_AND: res_o = a_i & b_i;
      OP_NOT: res_o = ~b_i;
      OP_MUL: ovf = seq_ovf_i;
      default: ;
    endcase
  end

  always_comb begin
    status_o       = '0;
    status_o[ST_Z] = (res_o == '0);
    status_o[ST_N] = res_o[MSB];
    status_o[ST_V] = ovf;
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle datapath ALU: start/busy/done handshake, iterative shift-add
// multiply and bit-serial shifts, registered result and {Z, N, V} status.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ALUop,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       status
);

  localparam logic [SHW:0] CNT_ONE = {{SHW{1'b0}}, 1'b1};

  alu_state_t         state_q, state_d;
  alu_op_t            op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [SHW:0]       cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [2:0]         status_q, status_d;

  alu_op_t            live_op, comb_op;
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   sh_cur, sh_step, sh_next;
  logic [WIDTH-1:0]   seq_res, comb_res;
  logic               seq_ovf;
  logic [2:0]         comb_status;

  assign live_op = alu_op_t'(ALUop);
  assign comb_op = (state_q == S_EXEC) ? op_q : live_op;

  // Multiplier sits in the low half of acc_q; each step adds A to the high half and shifts right.
  assign mul_addend = acc_q[0] ? a_q : '0;
  assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
  assign mul_next   = {mul_sum, acc_q[WIDTH-1:1]};

  assign sh_cur = acc_q[WIDTH-1:0];
  always_comb begin
    sh_step = sh_cur >> 1;
    case (op_q)
      OP_LSL:  sh_step = sh_cur << 1;
      OP_ASR:  sh_step = {sh_cur[WIDTH-1], sh_cur[WIDTH-1:1]};
      default: ;
    endcase
  end
  // A zero shift amount still spends one EXEC cycle, just without moving any bits.
  assign sh_next = (cnt_q == '0) ? sh_cur : sh_step;

  assign seq_res = (op_q == OP_MUL) ? mul_next[WIDTH-1:0] : sh_next;
  assign seq_ovf = |mul_next[2*WIDTH-1:WIDTH];

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op_i      (comb_op),
    .a_i       (Ain),
    .b_i       (Bin),
    .seq_res_i (seq_res),
    .seq_ovf_i (seq_ovf),
    .res_o     (comb_res),
    .status_o  (comb_status)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    out_d    = out_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!ALUop[2]) begin
            out_d    = comb_res;
            status_d = comb_status;
            done_d   = 1'b1;
          end else begin
            op_d    = live_op;
            a_d     = Ain;
            busy_d  = 1'b1;
            state_d = S_EXEC;
            if (live_op == OP_MUL) begin
              acc_d = {{WIDTH{1'b0}}, Bin};
              cnt_d = WIDTH[SHW:0];
            end else begin
              acc_d = {{WIDTH{1'b0}}, Ain};
              cnt_d = {1'b0, Bin[SHW-1:0]};
            end
          end
        end
      end
      default: begin
        acc_d = (op_q == OP_MUL) ? mul_next : {{WIDTH{1'b0}}, sh_next};
        if (cnt_q <= CNT_ONE) begin
          out_d    = comb_res;
          status_d = comb_status;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      out_q    <= '0;
      status_q <= STATUS_RST;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      out_q    <= out_d;
      status_q <= status_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign out    = out_q;
  assign status = status_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16): expected results are queued at
// each accepted start and compared when done pulses; tasks check timing and spot values.
module tb_alu_seq;

  typedef struct packed {
    logic [15:0] res;
    logic [2:0]  st;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  ALUop = 3'b000;
  logic [15:0] Ain = 16'h0;
  logic [15:0] Bin = 16'h0;
  logic        busy;
  logic        done;
  logic [15:0] out;
  logic [2:0]  status;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  exp_t sb_e;

  alu_seq #(.WIDTH(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .ALUop  (ALUop),
    .Ain    (Ain),
    .Bin    (Bin),
    .busy   (busy),
    .done   (done),
    .out    (out),
    .status (status)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t r;
    int s;
    int sh;
    logic [31:0] p;
    logic signed [15:0] sa;
    logic v;
    sa = a;
    sh = int'(b[3:0]);
    v = 1'b0;
    r.res = 16'h0;
    case (op)
      3'd0: begin s = int'(sa) + int'($signed(b)); r.res = a + b; v = (s > 32767) || (s < -32768); end
      3'd1: begin s = int'(sa) - int'($signed(b)); r.res = a - b; v = (s > 32767) || (s < -32768); end
      3'd2: r.res = a & b;
      3'd3: r.res = ~b;
      3'd4: begin p = {16'h0, a} * {16'h0, b}; r.res = p[15:0]; v = (p[31:16] != 16'h0); end
      3'd5: r.res = a << sh;
      3'd6: r.res = a >> sh;
      default: r.res = sa >>> sh;
    endcase
    r.st = {(r.res == 16'h0), r.res[15], v};
    return r;
  endfunction

  function automatic int exp_off(input logic [2:0] op, input logic [15:0] b);
    if (!op[2]) return 0;
    if (op == 3'd4) return 16;
    return (b[3:0] == 4'h0) ? 1 : int'(b[3:0]);
  endfunction

  // Scoreboard: every done pulse consumes one queued expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      n_cmp++;
      if (busy !== 1'b0) begin
        n_err++;
        $display("FAIL busy_done_overlap busy=%0b required 0 while done=1", busy);
      end
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_done out=%h with no outstanding start", out);
      end else begin
        sb_e = sb_q.pop_front();
        if (out !== sb_e.res) begin
          n_err++;
          $display("FAIL sb_out got %h expected %h", out, sb_e.res);
        end
        n_cmp++;
        if (status !== sb_e.st) begin
          n_err++;
          $display("FAIL sb_status got %b expected %b", status, sb_e.st);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    start = 1'b1;
    ALUop = op;
    Ain   = a;
    Bin   = b;
    sb_q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Returns the done edge offset from the start edge and the number of busy cycles seen.
  task automatic wait_done(input int inject, output int off, output int busy_cnt);
    off = 0;
    busy_cnt = 0;
    while (!done && off < 200) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      off++;
      if (off == inject) begin
        start = 1'b1;
        ALUop = 3'b000;
        Ain   = 16'h1111;
        Bin   = 16'h2222;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout waited %0d cycles without done", off);
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL reset_handshake busy/done=%b expected 00", {busy, done}); end
    n_cmp++;
    if (out !== 16'h0) begin n_err++; $display("FAIL reset_out got %h expected 0000", out); end
    n_cmp++;
    if (status !== 3'b100) begin n_err++; $display("FAIL reset_status got %b expected 100", status); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    int off, bc;
    issue(3'd0, 16'h7FFF, 16'h0001);
    wait_done(-1, off, bc);
    n_cmp++;
    if (off !== 0) begin n_err++; $display("FAIL add_latency done offset %0d expected 0", off); end
    n_cmp++;
    if (bc !== 0) begin n_err++; $display("FAIL add_busy busy cycles %0d expected 0", bc); end
    n_cmp++;
    if ({out, status} !== {16'h8000, 3'b011}) begin
      n_err++; $display("FAIL add_overflow got %h/%b expected 8000/011", out, status);
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; ALUop = 3'd1; Ain = 16'h0005; Bin = 16'h0005;
    sb_q.push_back(model(3'd1, 16'h0005, 16'h0005));
    @(posedge clk);
    #1;
    n_cmp++;
    if ({done, out, status} !== {1'b1, 16'h0000, 3'b100}) begin
      n_err++; $display("FAIL sub_zero got done=%b %h/%b expected 1 0000/100", done, out, status);
    end
    // Keep start high into the done cycle with a new op.
    ALUop = 3'd3; Ain = 16'hAAAA; Bin = 16'h00FF;
    sb_q.push_back(model(3'd3, 16'hAAAA, 16'h00FF));
    @(posedge clk);
    #1;
    start = 1'b0;
    n_cmp++;
    if ({done, out, status} !== {1'b1, 16'hFF00, 3'b010}) begin
      n_err++; $display("FAIL b2b_not got done=%b %h/%b expected 1 FF00/010", done, out, status);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_mul_ignore();
    int off, bc;
    issue(3'd4, 16'h0100, 16'h0100);
    wait_done(4, off, bc);
    n_cmp++;
    if (off !== 16) begin n_err++; $display("FAIL mul_latency done offset %0d expected 16", off); end
    n_cmp++;
    if (bc !== 16) begin n_err++; $display("FAIL mul_busy busy cycles %0d expected 16", bc); end
    n_cmp++;
    if ({out, status} !== {16'h0000, 3'b101}) begin
      n_err++; $display("FAIL mul_ovf got %h/%b expected 0000/101", out, status);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, out} !== {2'b00, 16'h0000}) begin
      n_err++; $display("FAIL mul_ignored_start got busy/done=%b out=%h expected 00 0000", {busy, done}, out);
    end
  endtask

  task automatic test_shifts();
    int off, bc;
    issue(3'd7, 16'h8000, 16'hFFF3);
    wait_done(-1, off, bc);
    n_cmp++;
    if (off !== 3 || bc !== 3) begin n_err++; $display("FAIL asr_latency offset %0d busy %0d expected 3/3", off, bc); end
    n_cmp++;
    if ({out, status} !== {16'hF000, 3'b010}) begin n_err++; $display("FAIL asr got %h/%b expected F000/010", out, status); end
    issue(3'd6, 16'h8000, 16'h0003);
    wait_done(-1, off, bc);
    n_cmp++;
    if (out !== 16'h1000) begin n_err++; $display("FAIL lsr got %h expected 1000", out); end
    issue(3'd5, 16'h1234, 16'h0000);
    wait_done(-1, off, bc);
    n_cmp++;
    if (off !== 1 || out !== 16'h1234) begin
      n_err++; $display("FAIL lsl0 offset %0d out %h expected 1/1234", off, out);
    end
  endtask

  task automatic test_random();
    int off, bc;
    logic [15:0] a, b;
    for (int i = 0; i < 16; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (i == 12) b = 16'hFFF0;
      issue(3'(i), a, b);
      wait_done(-1, off, bc);
      n_cmp++;
      if (off !== exp_off(3'(i), b) || bc !== (3'(i) < 3'd4 ? 0 : off)) begin
        n_err++;
        $display("FAIL rand_timing op=%0d offset %0d busy %0d expected %0d", i % 8, off, bc, exp_off(3'(i), b));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_async_reset();
    int off, bc, n_done;
    issue(3'd4, 16'h0003, 16'h0005);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, out, status} !== {2'b00, 16'h0000, 3'b100}) begin
      n_err++; $display("FAIL async_reset got busy/done=%b out=%h st=%b expected 00 0000 100", {busy, done}, out, status);
    end
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    n_cmp++;
    if (n_done !== 0) begin n_err++; $display("FAIL reset_no_done saw %0d done pulses expected 0", n_done); end
    issue(3'd4, 16'h0003, 16'h0005);
    wait_done(-1, off, bc);
    n_cmp++;
    if (off !== 16 || out !== 16'h000F || status !== 3'b000) begin
      n_err++; $display("FAIL mul_restart offset %0d out %h st %b expected 16 000F 000", off, out, status);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_mul_ignore();
    test_shifts();
    test_random();
    test_async_reset();
    @(posedge clk);
    #1;
    n_cmp++;
    if (sb_q.size() !== 0) begin n_err++; $display("FAIL sb_leftover %0d results never produced", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
